srf_stream_agu: RTL and testbench

Stream address generator and beat packer for S-morph SRF traffic. Sits directly upstream of the memory tile's network-side port. It accepts a stream descriptor (base, stride, count) and issues one element read at a time to the tile. It then packs the returned 64-bit elements into 256-bit beats for near-core consumers, with a valid/ready handshake and a last-beat marker.

---
 rtl/srf_stream_agu_pkg.sv | 25 ++
 rtl/srf_beat_packer.sv | 55 +++++
 rtl/srf_stream_agu.sv | 172 +++++++++++++++++
 tb/tb_srf_stream_agu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/srf_stream_agu_pkg.sv
// Shared types and constants for the SRF stream address generator and the
// memory tile's wide channel.
package srf_stream_agu_pkg;

  localparam int SRF_LANES  = 4;
  localparam int SRF_ELEM_W = 64;
  localparam int SRF_ADDR_W = 32;
  localparam int SRF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IDX_REQ  = 2'd1,
    ST_DATA_REQ = 2'd2,
    ST_EMIT     = 2'd3
  } agu_state_t;

  typedef struct packed {
    logic [SRF_ADDR_W-1:0] base;
    logic [SRF_ADDR_W-1:0] stride;
    logic [SRF_CNT_W-1:0]  count;
    logic                  indirect;
    logic [SRF_ADDR_W-1:0] idx_base;
  } srf_desc_t;

endpackage

// File: rtl/srf_beat_packer.sv
// Packs returned elements into a LANES-wide beat; holds the beat stable until
// popped, then clears data, mask and lane pointer together.
module srf_beat_packer #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [ELEM_W-1:0]         wr_data,
  input  logic                      pop,
  output logic                      lane_last,
  output logic [LANES*ELEM_W-1:0]   beat_data,
  output logic [LANES-1:0]          beat_mask
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0][ELEM_W-1:0] data_q, data_d;
  logic [LANES-1:0]             mask_q, mask_d;
  logic [LW-1:0]                ptr_q, ptr_d;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    ptr_d  = ptr_q;
    if (clr || pop) begin
      data_d = '0;
      mask_d = '0;
      ptr_d  = '0;
    end else if (wr_en) begin
      data_d[ptr_q] = wr_data;
      mask_d[ptr_q] = 1'b1;
      ptr_d         = ptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      ptr_q  <= ptr_d;
    end
  end

  assign lane_last = (ptr_q == LW'(LANES - 1));
  assign beat_data = data_q;
  assign beat_mask = mask_q;

endmodule

// File: rtl/srf_stream_agu.sv
// Stream address generator + beat packer for S-morph SRF traffic.
// Define SRF_AGU_INDIRECT_EN to enable index-array gather (IDX_REQ state).
module srf_stream_agu
  import srf_stream_agu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ELEM_W     = 64,
  parameter int LANES      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [ADDR_WIDTH-1:0]    desc_base,
  input  logic [ADDR_WIDTH-1:0]    desc_stride,
  input  logic [CNT_W-1:0]         desc_count,
  input  logic                     desc_indirect,
  input  logic [ADDR_WIDTH-1:0]    desc_idx_base,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic                     mem_rd_req,
  input  logic                     mem_ack,
  input  logic [ELEM_W-1:0]        mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ELEM_W-1:0]  out_data,
  output logic [LANES-1:0]         out_mask,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  agu_state_t             state_q, state_d;
  srf_desc_t              desc_q, desc_d;
  logic [CNT_W-1:0]       i_q, i_d, i_inc;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   done_q, done_d;
  logic                   pk_clr, pk_wr, pk_pop, lane_last;
  logic                   ind_mode, ind_next;

`ifdef SRF_AGU_INDIRECT_EN
  localparam int ESH = $clog2(ELEM_W / 8);
  logic [ADDR_WIDTH-1:0]  idx_addr_q, idx_addr_d;
  assign ind_mode = desc_q.indirect;
  assign ind_next = desc_indirect;
`else
  logic unused_indirect;
  assign ind_mode = 1'b0;
  assign ind_next = 1'b0;
  assign unused_indirect = ^{desc_q.indirect, desc_q.idx_base};
`endif

  assign i_inc = i_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    i_d        = i_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    pk_clr     = 1'b0;
    pk_wr      = 1'b0;
    pk_pop     = 1'b0;
    desc_ready = 1'b0;
    mem_rd_req = 1'b0;
    mem_addr   = '0;
    out_valid  = 1'b0;
`ifdef SRF_AGU_INDIRECT_EN
    idx_addr_d = idx_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          desc_d.base     = desc_base;
          desc_d.stride   = desc_stride;
          desc_d.count    = desc_count;
          desc_d.indirect = desc_indirect;
          desc_d.idx_base = desc_idx_base;
          i_d             = '0;
          addr_d          = desc_base;
          pk_clr          = 1'b1;
`ifdef SRF_AGU_INDIRECT_EN
          idx_addr_d      = desc_idx_base;
`endif
          if (desc_count == '0) done_d = 1'b1;
          else if (ind_next)    state_d = ST_IDX_REQ;
          else                  state_d = ST_DATA_REQ;
        end
      end
`ifdef SRF_AGU_INDIRECT_EN
      ST_IDX_REQ: begin
        mem_rd_req = 1'b1;
        mem_addr   = idx_addr_q;
        if (mem_ack) begin
          // Gather target: element-scaled index from the low 32 bits, wrapping.
          addr_d     = desc_q.base + (ADDR_WIDTH'(mem_rdata[31:0]) << ESH);
          idx_addr_d = idx_addr_q + ADDR_WIDTH'(ELEM_W / 8);
          state_d    = ST_DATA_REQ;
        end
      end
`endif
      ST_DATA_REQ: begin
        mem_rd_req = 1'b1;
        mem_addr   = addr_q;
        if (mem_ack) begin
          pk_wr = 1'b1;
          i_d   = i_inc;
          if (!ind_mode) addr_d = addr_q + desc_q.stride;
          if (lane_last || i_inc == desc_q.count) state_d = ST_EMIT;
          else if (ind_mode)                      state_d = ST_IDX_REQ;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pk_pop = 1'b1;
          if (out_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ind_mode ? ST_IDX_REQ : ST_DATA_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      desc_q  <= '0;
      i_q     <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      i_q     <= i_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

`ifdef SRF_AGU_INDIRECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_addr_q <= '0;
    else        idx_addr_q <= idx_addr_d;
  end
`endif

  srf_beat_packer #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .wr_en     (pk_wr),
    .wr_data   (mem_rdata),
    .pop       (pk_pop),
    .lane_last (lane_last),
    .beat_data (out_data),
    .beat_mask (out_mask)
  );

  assign out_last = (state_q == ST_EMIT) && (i_q == desc_q.count);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_srf_stream_agu.sv
// Directed scoreboard bench for srf_stream_agu: expected addresses and beats
// are queued at descriptor issue and popped as the DUT requests and emits.
module tb_srf_stream_agu;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         desc_valid = 1'b0;
  logic         desc_ready;
  logic [31:0]  desc_base = '0, desc_stride = '0, desc_idx_base = '0;
  logic [15:0]  desc_count = '0;
  logic         desc_indirect = 1'b0;
  logic [31:0]  mem_addr;
  logic         mem_rd_req;
  logic         mem_ack = 1'b0;
  logic [63:0]  mem_rdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_data;
  logic [3:0]   out_mask;
  logic         out_last;
  logic         busy;
  logic         done;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   mask;
    logic         last;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_addr[$];
  int          tests = 0, fails = 0, done_cnt = 0, ack_cnt = 0;

  srf_stream_agu dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_base(desc_base), .desc_stride(desc_stride), .desc_count(desc_count),
    .desc_indirect(desc_indirect), .desc_idx_base(desc_idx_base),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] rd(input logic [31:0] a);
    if (a == 32'h200) return 64'hAAAA_5555_0000_0003;
    if (a == 32'h208) return 64'hBBBB_6666_0000_0000;
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] base, input logic [31:0] stride, input int count);
    logic [31:0] a;
    beat_t       b;
    int          lane;
    a = base; lane = 0;
    b.data = '0; b.mask = '0; b.last = 1'b0;
    for (int k = 0; k < count; k++) begin
      exp_addr.push_back(a);
      b.data[64*lane +: 64] = rd(a);
      b.mask[lane] = 1'b1;
      lane++;
      a = a + stride;
      if (lane == 4 || k == count - 1) begin
        b.last = (k == count - 1);
        exp_beats.push_back(b);
        b.data = '0; b.mask = '0; b.last = 1'b0;
        lane = 0;
      end
    end
  endtask

  task automatic send_desc(input logic [31:0] base, input logic [31:0] stride,
                           input logic [15:0] cnt, input logic ind, input logic [31:0] ib);
    int t;
    t = 0;
    while (!desc_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!desc_ready) chk("desc_ready_timeout", desc_ready, 1);
    desc_valid = 1'b1; desc_base = base; desc_stride = stride; desc_count = cnt;
    desc_indirect = ind; desc_idx_base = ib;
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 500) begin @(posedge clk); #1; t++; end
    chk("done_count", done_cnt, target);
    chk("addr_queue_drained", exp_addr.size(), 0);
    chk("beat_queue_drained", exp_beats.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_single_pulse", done_cnt, target);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_desc_ready"}, desc_ready, 1);
    chk({tag, "_mem_rd_req"}, mem_rd_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_mask"}, out_mask, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Memory tile model and output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end else begin
      if (out_valid) chk("no_req_in_emit", mem_rd_req, 0);
      if (out_valid && out_ready) begin
        if (exp_beats.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_beats.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_mask", out_mask, e.mask);
          chk("beat_last", out_last, e.last);
        end
      end
      if (done) done_cnt++;
      if (mem_rd_req) begin
        if (exp_addr.size() == 0) chk("unexpected_req", mem_addr, 32'hFFFF_FFFF);
        else chk("mem_addr", mem_addr, exp_addr.pop_front());
        mem_ack   = 1'b1;
        mem_rdata = rd(mem_addr);
        ack_cnt++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  initial begin
    int lat, a0, t;
    logic [255:0] held;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full strided beat + minimum latency
    push_stream(32'h100, 32'h8, 4);
    send_desc(32'h100, 32'h8, 16'd4, 1'b0, 32'h0);
    chk("busy_after_accept", busy, 1);
    chk("req_cycle1", mem_rd_req, 1);
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("beat_latency", lat, 5);
    wait_done(1);
    chk("desc_ready_after_done", desc_ready, 1);

    // partial final beat
    push_stream(32'h2000, 32'h8, 6);
    send_desc(32'h2000, 32'h8, 16'd6, 1'b0, 32'h0);
    wait_done(2);

    // backpressure on the first of two beats
    out_ready = 1'b0;
    push_stream(32'h3000, 32'h20, 8);
    send_desc(32'h3000, 32'h20, 16'd8, 1'b0, 32'h0);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bp_valid_seen", out_valid, 1);
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_stable", out_data, held);
      chk("bp_no_req", mem_rd_req, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_resume_req", mem_rd_req, 1);
    wait_done(3);

    // address wrap, then zero-count descriptor
    push_stream(32'hFFFF_FFF8, 32'h10, 2);
    send_desc(32'hFFFF_FFF8, 32'h10, 16'd2, 1'b0, 32'h0);
    wait_done(4);
    send_desc(32'h500, 32'h8, 16'd0, 1'b0, 32'h0);
    chk("zero_done", done, 1);
    chk("zero_no_req", mem_rd_req, 0);
    chk("zero_busy", busy, 0);
    chk("zero_no_beat", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_done_count", done_cnt, 5);
    chk("zero_done_low", done, 0);

    // reset after two of four acks
    push_stream(32'h4000, 32'h8, 4);
    a0 = ack_cnt;
    send_desc(32'h4000, 32'h8, 16'd4, 1'b0, 32'h0);
    t = 0;
    while (ack_cnt < a0 + 2 && t < 50) begin @(posedge clk); #1; t++; end
    chk("midrst_acks", ack_cnt, a0 + 2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_addr.delete();
    exp_beats.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_done", done_cnt, 5);
    push_stream(32'h6000, 32'h8, 4);
    send_desc(32'h6000, 32'h8, 16'd4, 1'b0, 32'h0);
    wait_done(6);

`ifdef SRF_AGU_INDIRECT_EN
    begin
      beat_t b;
      exp_addr.push_back(32'h200);
      exp_addr.push_back(32'h1018);
      exp_addr.push_back(32'h208);
      exp_addr.push_back(32'h1000);
      b.data = '0;
      b.data[63:0]   = rd(32'h1018);
      b.data[127:64] = rd(32'h1000);
      b.mask = 4'b0011;
      b.last = 1'b1;
      exp_beats.push_back(b);
      send_desc(32'h1000, 32'h0, 16'd2, 1'b1, 32'h200);
      wait_done(7);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
